// File: rtl/alu_iter_exec.sv
// alu_iter_exec -- iterative ALU execution unit.
//
// Single-cycle logic/arithmetic ops are registered on the accept edge.
// Shifts are performed one bit per cycle from an accumulator, so a shift by
// N presents its result N+1 cycles after accept.
//
// Ports:
//   clk        clock, all state updates on rising edge
//   reset      asynchronous, active-high reset
//   in_valid   request valid            in_ready  block idle, can accept
//   operation  4-bit op code            a, b      operands (b[SW-1:0] = shamt)
//   out_valid  result valid (DONE)      out_ready consumer takes result
//   result     registered result        zero      registered (result == 0)
//   illegal    registered flag, op code was not recognised
module alu_iter_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       operation,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [SW-1:0] CNT_ONE = SW'(1);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_XOR = 4'b1100;
  localparam logic [3:0] OP_SLL = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SRA = 4'b1010;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;
  typedef enum logic [1:0] {SK_SLL, SK_SRL, SK_SRA} shift_kind_t;

  state_t           state_q, state_d;
  shift_kind_t      kind_q, kind_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic [WIDTH-1:0] alu_val;
  logic [WIDTH-1:0] acc_shifted;
  logic             op_legal;
  logic             op_shift;
  shift_kind_t      op_kind;

  // Op decode of the live request inputs; only consulted on the accept cycle.
  always_comb begin
    alu_val  = '0;
    op_legal = 1'b1;
    op_shift = 1'b0;
    op_kind  = SK_SLL;
    unique case (operation)
      OP_AND: alu_val = a & b;
      OP_OR:  alu_val = a | b;
      OP_ADD: alu_val = a + b;
      OP_SUB: alu_val = a - b;
      OP_SLT: alu_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_XOR: alu_val = a ^ b;
      OP_SLL: begin op_shift = 1'b1; op_kind = SK_SLL; end
      OP_SRL: begin op_shift = 1'b1; op_kind = SK_SRL; end
      OP_SRA: begin op_shift = 1'b1; op_kind = SK_SRA; end
      default: op_legal = 1'b0;
    endcase
  end

  // One-bit step of the accumulator for the shift kind latched at accept.
  always_comb begin
    unique case (kind_q)
      SK_SLL:  acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
      SK_SRL:  acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
      default: acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!op_legal) begin
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = ST_DONE;
          end else if (op_shift) begin
            kind_d = op_kind;
            acc_d  = a;
            cnt_d  = b[SW-1:0];
            if (b[SW-1:0] == '0) begin
              // Zero shift amount: result is the unshifted source.
              result_d  = a;
              zero_d    = (a == '0);
              illegal_d = 1'b0;
              state_d   = ST_DONE;
            end else begin
              state_d = ST_SHIFT;
            end
          end else begin
            result_d  = alu_val;
            zero_d    = (alu_val == '0);
            illegal_d = 1'b0;
            state_d   = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        acc_d = acc_shifted;
        cnt_d = cnt_q - CNT_ONE;
        // The step that empties the counter publishes the result directly.
        if (cnt_q == CNT_ONE) begin
          result_d  = acc_shifted;
          zero_d    = (acc_shifted == '0);
          illegal_d = 1'b0;
          state_d   = ST_DONE;
        end
      end
      default: begin
        if (out_ready) state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      kind_q    <= SK_SLL;
      acc_q     <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter_exec.sv
module tb_alu_iter_exec;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   operation;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_checks = 0;
  int n_pass   = 0;

  alu_iter_exec #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .a(a), .b(b), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ill;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: direct arithmetic on the op code meaning.
  task automatic model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic ill, output int lat);
    int sh;
    sh  = int'(y % W);
    ill = 1'b0;
    lat = 1;
    r   = '0;
    case (op)
      4'h0: r = x & y;
      4'h1: r = x | y;
      4'h2: r = x + y;
      4'h6: r = x - y;
      4'h7: r = ($signed(x) < $signed(y)) ? 1 : 0;
      4'hC: r = x ^ y;
      4'h8: begin r = x << sh; lat = 1 + sh; end
      4'h9: begin r = x >> sh; lat = 1 + sh; end
      4'hA: begin r = $signed(x) >>> sh; lat = 1 + sh; end
      default: ill = 1'b1;
    endcase
  endtask

  // Issue one request and check the result, flags and latency, then consume it.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic eill,
                        input int elat);
    int lat;
    int waitc;
    waitc = 0;
    while (!in_ready && waitc < 4) begin @(posedge clk); #1; waitc++; end
    in_valid = 1'b1; operation = op; a = x; b = y;
    @(posedge clk); #1;
    in_valid = 1'b0; operation = 4'($urandom); a = $urandom; b = $urandom;
    lat = 1;
    while (!out_valid && lat <= W + 3) begin @(posedge clk); #1; lat++; end
    $display("op %s: op=%h a=%h b=%h -> result=%h zero=%b illegal=%b lat=%0d",
             tag, op, x, y, result, zero, illegal, lat);
    check({tag, " latency"}, W'(lat), W'(elat));
    check({tag, " result"}, result, er);
    check({tag, " zero"}, W'(zero), W'(er == '0));
    check({tag, " illegal"}, W'(illegal), W'(eill));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " back to idle"}, W'({in_ready, out_valid}), W'(2'b10));
  endtask

  vec_t vecs[11];

  initial begin
    logic [W-1:0] hold_res;
    logic [W-1:0] mr;
    logic         mill;
    int           mlat;
    int           seen;
    logic [3:0]   ops[10];

    vecs[0]  = '{4'h2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1'b0, 1};
    vecs[1]  = '{4'h6, 32'h5,         32'h5,         32'h0,         1'b0, 1};
    vecs[2]  = '{4'h7, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1};
    vecs[3]  = '{4'h7, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0, 1};
    vecs[4]  = '{4'hA, 32'h8000_0000, 32'd31,        32'hFFFF_FFFF, 1'b0, 32};
    vecs[5]  = '{4'h8, 32'h1234_5678, 32'h0,         32'h1234_5678, 1'b0, 1};
    vecs[6]  = '{4'h9, 32'hF0,        32'd36,        32'h0F,        1'b0, 5};
    vecs[7]  = '{4'h3, 32'h5,         32'h6,         32'h0,         1'b1, 1};
    vecs[8]  = '{4'h0, 32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 1};
    vecs[9]  = '{4'h1, 32'hF0F0,      32'h0F0F,      32'hFFFF,      1'b0, 1};
    vecs[10] = '{4'hC, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1'b0, 1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    operation = '0; a = '0; b = '0;
    #3;
    check("reset in_ready/out_valid", W'({in_ready, out_valid}), W'(2'b10));
    check("reset result", result, '0);
    check("reset flags", W'({zero, illegal}), W'(2'b00));
    @(posedge clk); #1;
    reset = 1'b0;

    // Directed table, first op immediately after reset release.
    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].ill, vecs[i].lat);

    // Result held in DONE while the consumer stalls; new requests ignored.
    in_valid = 1'b1; operation = 4'h2; a = 32'd100; b = 32'd23;
    @(posedge clk); #1;
    operation = 4'h6; a = 32'hDEAD; b = 32'hBEEF;
    hold_res = 32'd123;
    for (int c = 0; c < 10; c++) begin
      $display("stall cycle %0d: result=%h in_ready=%b out_valid=%b", c, result, in_ready, out_valid);
      check("stall result", result, hold_res);
      check("stall handshake", W'({in_ready, out_valid}), W'(2'b01));
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall release idle", W'({in_ready, out_valid}), W'(2'b10));
    check("stall result kept in idle", result, hold_res);

    // Reset during a long shift: abandoned, no output pulse.
    in_valid = 1'b1; operation = 4'h8; a = 32'h1; b = 32'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("mid-shift reset handshake", W'({in_ready, out_valid}), W'(2'b10));
    check("mid-shift reset result", result, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    $display("post-reset watch: out_valid cycles=%0d", seen);
    check("no pulse after reset", W'(seen), '0);
    run_op("after reset", 4'h2, 32'd40, 32'd2, 32'd42, 1'b0, 1);

    // Randomized ops against the reference model.
    ops = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'h9, 4'hA, 4'hF};
    for (int i = 0; i < 40; i++) begin
      logic [3:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      rop = (i % 7 == 6) ? 4'($urandom) : ops[$urandom_range(0, 9)];
      ra  = (i % 5 == 0) ? 32'h8000_0000 | $urandom : $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      model(rop, ra, rb, mr, mill, mlat);
      run_op($sformatf("rand%0d", i), rop, ra, rb, mr, mill, mlat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
